// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants, FSM encoding and entry sizing for the instruction fetch unit.
package instr_fetch_unit_pkg;

  localparam int          INSTR_WIDTH = 16;
  localparam logic [15:0] RESET_PC    = 16'h0000;
  localparam logic [3:0]  HALT_OPCODE = 4'hF;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  // Each prefetch entry carries the instruction word above its byte address.
  function automatic int entryWidth(input int addrWidth);
    return INSTR_WIDTH + addrWidth;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Small prefetch FIFO: push/pop/flush, same-cycle push+pop legal when full,
// head forced to zero when empty.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH = PTR_WIDTH + 1;

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [PTR_WIDTH-1:0] wrPtr_q;
  logic [PTR_WIDTH-1:0] rdPtr_q;
  logic [CNT_WIDTH-1:0] count_q;

  // Flush wins over any push or pop presented in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wrPtr_q] <= data_i;
        wrPtr_q        <= wrPtr_q + PTR_WIDTH'(1);
      end
      if (pop_i) begin
        rdPtr_q <= rdPtr_q + PTR_WIDTH'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_WIDTH'(1);
        2'b01:   count_q <= count_q - CNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = (count_q == '0) ? '0 : mem_q[rdPtr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the combinational instruction
// memory into a prefetch FIFO and hands words to decode until HLT retires.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DEPTH       = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(instr_fetch_unit_pkg::RESET_PC),
  parameter logic [3:0]            HALT_OPCODE = instr_fetch_unit_pkg::HALT_OPCODE
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_en,
  output logic                  imem_wr,
  output logic [15:0]           imem_data_in,
  input  logic [15:0]           imem_data_out,
  output logic [15:0]           instr_out,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  halted
);

  import instr_fetch_unit_pkg::*;

  localparam int ENTRY_WIDTH = entryWidth(ADDR_WIDTH);
  localparam int CNT_WIDTH   = $clog2(DEPTH) + 1;
  localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

  fetch_state_e           state_q;
  logic                   halted_q;
  logic [ADDR_WIDTH-1:0]  pc_q;
  logic [ADDR_WIDTH-1:0]  pc_d;
  logic [CNT_WIDTH-1:0]   fifoCount;
  logic [ENTRY_WIDTH-1:0] headEntry;
  logic                   flush;
  logic                   pop;
  logic                   fetch;
  logic                   headIsHalt;
  logic                   captureIsHalt;

  // A halted unit ignores redirects, so only a live unit may flush.
  assign flush         = redirect & (state_q != HALTED);
  assign instr_valid   = (fifoCount != '0) & (state_q != HALTED);
  assign pop           = instr_valid & instr_ready;
  assign fetch         = ~rst & (state_q == FETCH) & ~redirect & ((fifoCount != FULL_COUNT) | pop);
  assign headIsHalt    = headEntry[ENTRY_WIDTH-1 -: 4] == HALT_OPCODE;
  assign captureIsHalt = imem_data_out[15:12] == HALT_OPCODE;

  assign imem_addr     = pc_q;
  assign imem_en       = fetch;
  assign imem_wr       = 1'b0;
  assign imem_data_in  = '0;
  assign instr_out     = headEntry[ENTRY_WIDTH-1 -: 16];
  assign instr_pc      = headEntry[ADDR_WIDTH-1:0];
  assign halted        = halted_q;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fetch),
    .pop_i   (pop & ~flush),
    .flush_i (flush),
    .data_i  ({imem_data_out, pc_q}),
    .head_o  (headEntry),
    .count_o (fifoCount)
  );

  always_comb begin
    pc_d = pc_q;
    if (flush) begin
      pc_d = {redirect_pc[ADDR_WIDTH-1:1], 1'b0};
    end else if (fetch) begin
      pc_d = pc_q + ADDR_WIDTH'(2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // The HLT entry is the last one in the FIFO, so popping it retires the program.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FETCH;
      halted_q <= 1'b0;
    end else if (flush) begin
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (fetch && captureIsHalt) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && headIsHalt) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

endmodule
